// File: rtl/sw_seq_feeder_if.sv
// Signal bundle between the sequence feeder, its host and the Smith-Waterman core.
// The feeder takes the slave side; the host/core side takes master.
interface sw_seq_feeder_if;
    logic        wr_en;
    logic        wr_sel;
    logic [7:0]  wr_addr;
    logic [1:0]  wr_data;
    logic        start;
    logic        core_rst;
    logic        valid;
    logic [1:0]  data_s;
    logic [1:0]  data_t;
    logic        finish;
    logic [11:0] max;
    logic        busy;
    logic        done;
    logic        error;
    logic [11:0] result;

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start, finish, max,
        output core_rst, valid, data_s, data_t, busy, done, error, result
    );

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start, finish, max,
        input  core_rst, valid, data_s, data_t, busy, done, error, result
    );
endinterface

// File: rtl/sw_seq_feeder.sv
// Host-side transmitter: holds one S and one T sequence, resets the SW core,
// streams both sequences as one valid burst, then collects the max score.
module sw_seq_feeder #(
    parameter int unsigned INPUT_LENGTH = 256,
    parameter int unsigned CLR_CYCLES   = 2,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic           clk,
    input  logic           reset,
    sw_seq_feeder_if.slave bus
);
    localparam int unsigned AW = $clog2(INPUT_LENGTH);
    localparam int unsigned CW = 16;

    typedef enum logic [2:0] {IDLE, CLR, STREAM, WAIT, DONE} state_t;

    state_t        state;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_next;
    logic [AW-1:0] wr_idx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          addr_ok;
    logic          wr_ok;
    logic [1:0]    s_mem [INPUT_LENGTH];
    logic [1:0]    t_mem [INPUT_LENGTH];

    // Out-of-range check only exists when the 8-bit address can exceed the depth
    generate
        if (INPUT_LENGTH < 256) begin : g_addr_chk
            assign addr_ok = (bus.wr_addr < 8'(INPUT_LENGTH));
        end else begin : g_addr_all
            assign addr_ok = 1'b1;
        end
    endgenerate

    always_comb begin
        wr_idx   = bus.wr_addr[AW-1:0];
        wr_ok    = bus.wr_en && (state == IDLE) && addr_ok;
        idx_next = idx + AW'(1);
        cnt_inc  = (cnt == '1) ? cnt : cnt + CW'(1);
    end

    // Sequence memories, writable only while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < INPUT_LENGTH; i++) begin
                s_mem[AW'(i)] <= '0;
                t_mem[AW'(i)] <= '0;
            end
        end else if (wr_ok) begin
            if (bus.wr_sel) t_mem[wr_idx] <= bus.wr_data;
            else            s_mem[wr_idx] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            cnt          <= '0;
            bus.core_rst <= 1'b0;
            bus.valid    <= 1'b0;
            bus.data_s   <= '0;
            bus.data_t   <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.error    <= 1'b0;
            bus.result   <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state        <= CLR;
                        cnt          <= '0;
                        bus.error    <= 1'b0;
                        bus.result   <= '0;
                        bus.core_rst <= 1'b1;
                        bus.busy     <= 1'b1;
                    end
                end
                CLR: begin
                    if (cnt == CW'(CLR_CYCLES - 1)) begin
                        state        <= STREAM;
                        bus.core_rst <= 1'b0;
                        bus.valid    <= 1'b1;
                        idx          <= '0;
                        bus.data_s   <= s_mem[0];
                        bus.data_t   <= t_mem[0];
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                STREAM: begin
                    // Exit on the last index so the index never wraps
                    if (idx == AW'(INPUT_LENGTH - 1)) begin
                        state      <= WAIT;
                        bus.valid  <= 1'b0;
                        bus.data_s <= '0;
                        bus.data_t <= '0;
                        cnt        <= '0;
                    end else begin
                        idx        <= idx_next;
                        bus.data_s <= s_mem[idx_next];
                        bus.data_t <= t_mem[idx_next];
                    end
                end
                WAIT: begin
                    cnt <= cnt_inc;
                    // finish takes priority over a simultaneous timeout
                    if (bus.finish) begin
                        bus.result <= bus.max;
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end else if (cnt_inc >= CW'(TIMEOUT)) begin
                        bus.error  <= 1'b1;
                        bus.result <= '0;
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sw_seq_feeder.sv
// Self-checking bench for sw_seq_feeder: stub core plus sequence-level reference model.
module tb_sw_seq_feeder;
    localparam int L   = 256;
    localparam int CLR = 2;
    localparam int TO  = 1024;

    logic clk = 1'b0;
    logic reset;

    sw_seq_feeder_if bus();

    sw_seq_feeder #(.INPUT_LENGTH(L), .CLR_CYCLES(CLR), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] ref_s [L];
    logic [1:0] ref_t [L];
    logic [1:0] cap_s5, cap_t5;

    typedef struct {
        int          fa;
        logic [11:0] mx;
        bit          exp_err;
        logic [11:0] exp_res;
        int          exp_wait;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_mem(input bit sel, input int addr, input logic [1:0] d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_addr = 8'(addr);
        bus.wr_data = d;
        if (sel) ref_t[addr] = d;
        else     ref_s[addr] = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    // One full run against the stub core; fa = WAIT cycle (1-based) on which finish rises, 0 = never
    task automatic do_run(input string tag, input int fa, input logic [11:0] mx, input bit stale,
                          input bit poke, input bit wr_same,
                          input bit exp_err, input logic [11:0] exp_res, input int exp_wait);
        int rst_cnt = 0, first_rst = -1, first_valid = -1, k = 0, gaps = 0;
        int bad_data = 0, waitc = 0, busy_bad = 0, early = 0;
        bit stream_over = 1'b0, got_done = 1'b0;
        logic        err_s = 1'b0;
        logic [11:0] res_s = '0;
        @(negedge clk);
        bus.start = 1'b1;
        if (wr_same) begin
            bus.wr_en   = 1'b1;
            bus.wr_sel  = 1'b1;
            bus.wr_addr = 8'd7;
            bus.wr_data = ~ref_t[7];
            ref_t[7]    = ~ref_t[7];
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 0 && (bus.error !== 1'b0 || bus.result !== 12'd0)) early++;
            if (bus.busy !== 1'b1) busy_bad++;
            if (bus.core_rst === 1'b1) begin
                rst_cnt++;
                if (first_rst < 0) first_rst = c;
                if (!stale) bus.finish = 1'b0;
            end
            if (bus.valid === 1'b1) begin
                if (first_valid < 0) first_valid = c;
                if (stream_over) gaps++;
                else if (k < L) begin
                    if (bus.data_s !== ref_s[k] || bus.data_t !== ref_t[k]) bad_data++;
                    if (k == 5) begin cap_s5 = bus.data_s; cap_t5 = bus.data_t; end
                end
                k++;
                if (poke && k == 51) begin
                    bus.start   = 1'b1;
                    bus.wr_en   = 1'b1;
                    bus.wr_sel  = 1'b0;
                    bus.wr_addr = 8'd0;
                    bus.wr_data = ~ref_s[0];
                end else begin
                    bus.start = 1'b0;
                    bus.wr_en = 1'b0;
                end
            end else begin
                bus.start = 1'b0;
                bus.wr_en = 1'b0;
                if (bus.valid !== 1'b0 || bus.data_s !== 2'd0 || bus.data_t !== 2'd0) bad_data++;
                if (bus.done === 1'b1) begin
                    got_done = 1'b1;
                    err_s    = bus.error;
                    res_s    = bus.result;
                    break;
                end
                if (k > 0) begin
                    stream_over = 1'b1;
                    waitc++;
                    if (stale && waitc == 1) bus.finish = 1'b0;
                    if (fa != 0 && waitc == fa) begin
                        bus.finish = 1'b1;
                        bus.max    = mx;
                    end
                end
            end
            @(negedge clk);
        end
        check({tag, ".core_rst_start"}, 32'(first_rst), 32'(0));
        check({tag, ".core_rst_len"},   32'(rst_cnt), 32'(CLR));
        check({tag, ".valid_start"},    32'(first_valid), 32'(CLR));
        check({tag, ".valid_len"},      32'(k), 32'(L));
        check({tag, ".valid_gaps"},     32'(gaps), 32'(0));
        check({tag, ".data_errs"},      32'(bad_data), 32'(0));
        check({tag, ".busy_low"},       32'(busy_bad), 32'(0));
        check({tag, ".clear_on_start"}, 32'(early), 32'(0));
        check({tag, ".done_seen"},      32'(got_done), 32'(1));
        check({tag, ".wait_cycles"},    32'(waitc), 32'(exp_wait));
        check({tag, ".error"},          32'(err_s), 32'(exp_err));
        check({tag, ".result"},         32'(res_s), 32'(exp_res));
        @(negedge clk);
        check({tag, ".busy_after"},     32'(bus.busy), 32'(0));
        check({tag, ".done_width"},     32'(bus.done), 32'(0));
        check({tag, ".error_hold"},     32'(bus.error), 32'(exp_err));
        check({tag, ".result_hold"},    32'(bus.result), 32'(exp_res));
    endtask

    initial begin
        int fa;
        logic [11:0] mx;
        bit e;
        int seen, dones;

        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        bus.finish  = 1'b0;
        bus.max     = '0;
        for (int i = 0; i < L; i++) begin ref_s[i] = 2'd0; ref_t[i] = 2'd0; end
        repeat (3) @(negedge clk);
        check("rst.busy",     32'(bus.busy), 32'(0));
        check("rst.done",     32'(bus.done), 32'(0));
        check("rst.error",    32'(bus.error), 32'(0));
        check("rst.result",   32'(bus.result), 32'(0));
        check("rst.valid",    32'(bus.valid), 32'(0));
        check("rst.core_rst", 32'(bus.core_rst), 32'(0));
        check("rst.data_s",   32'(bus.data_s), 32'(0));
        check("rst.data_t",   32'(bus.data_t), 32'(0));
        reset = 1'b0;

        // Table of stub-core behaviours over the i%4 / (i+1)%4 pattern
        for (int i = 0; i < L; i++) write_mem(1'b0, i, 2'(i % 4));
        for (int i = 0; i < L; i++) write_mem(1'b1, i, 2'((i + 1) % 4));
        vecs[0] = '{300,    12'h5A3, 1'b0, 12'h5A3, 300};
        vecs[1] = '{0,      12'h000, 1'b1, 12'h000, TO};
        vecs[2] = '{TO,     12'h7FF, 1'b0, 12'h7FF, TO};
        vecs[3] = '{1,      12'hABC, 1'b0, 12'hABC, 1};
        vecs[4] = '{TO + 1, 12'h111, 1'b1, 12'h000, TO};
        for (int i = 0; i < 5; i++) begin
            do_run($sformatf("vec%0d", i), vecs[i].fa, vecs[i].mx, 1'b0, 1'b0, 1'b0,
                   vecs[i].exp_err, vecs[i].exp_res, vecs[i].exp_wait);
            if (i == 0) begin
                check("vec0.data_s_k5", 32'(cap_s5), 32'(1));
                check("vec0.data_t_k5", 32'(cap_t5), 32'(2));
            end
        end

        // Write and start while busy are ignored; following run still streams the old S[0]
        do_run("poke", 50, 12'h0F0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0F0, 50);
        do_run("after_poke", 20, 12'h00F, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00F, 20);
        check("after_poke.s0", 32'(ref_s[0]), 32'(0));

        // Write on the same edge as start lands in the stream
        do_run("wr_same", 40, 12'h246, 1'b0, 1'b0, 1'b1, 1'b0, 12'h246, 40);

        // Randomized contents and finish timing against the model
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < L; i++) write_mem(1'b0, i, 2'($urandom));
            for (int i = 0; i < L; i++) write_mem(1'b1, i, 2'($urandom));
            fa = (r == 0) ? 0 : int'($urandom_range(1, TO + 60));
            mx = 12'($urandom);
            e  = (fa == 0 || fa > TO);
            do_run($sformatf("rand%0d", r), fa, mx, 1'b0, 1'b0, 1'b0,
                   e, e ? 12'h000 : mx, e ? TO : fa);
        end

        // Back-to-back runs; run 2 sees a stale finish with a bogus score through CLR/STREAM
        do_run("b2b_1", 200, 12'h321, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321, 200);
        bus.max = 12'hBAD;
        do_run("b2b_2", 200, 12'h321, 1'b1, 1'b0, 1'b0, 1'b0, 12'h321, 200);

        // Reset in the middle of a stream aborts immediately and clears memories
        bus.finish = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 0;
        for (int c = 0; c < 400 && seen < 101; c++) begin
            if (bus.valid === 1'b1) seen++;
            if (seen < 101) @(negedge clk);
        end
        check("abort.reached_k100", 32'(seen), 32'(101));
        reset = 1'b1;
        #1;
        check("abort.valid",    32'(bus.valid), 32'(0));
        check("abort.busy",     32'(bus.busy), 32'(0));
        check("abort.core_rst", 32'(bus.core_rst), 32'(0));
        check("abort.done",     32'(bus.done), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < L; i++) begin ref_s[i] = 2'd0; ref_t[i] = 2'd0; end
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) dones++;
        end
        check("abort.quiet", 32'(dones), 32'(0));
        do_run("post_abort", 10, 12'h0AA, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0AA, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sw_seq_feeder.md
Name: sw_seq_feeder

Overview:
- Host-side transmitter for the Smith-Waterman core input stream.
- Stores one S and one T sequence of 2-bit nucleotides, loaded over a simple write port.
- On start it pulses the core reset, then streams both sequences to the core as one contiguous valid burst.
- It then waits for the core's finish, captures the 12-bit max score, and reports done or timeout to the host.

Parameters:
- INPUT_LENGTH, 256, symbols per sequence streamed per run; the address width is clog2(INPUT_LENGTH).
- CLR_CYCLES, 2, number of cycles core_rst is held high before streaming.
- TIMEOUT, 1024, maximum WAIT cycles allowed for finish before error is raised.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  host write strobe for sequence memory.
- wr_sel  in  1  memory select: 0 = S memory, 1 = T memory.
- wr_addr  in  8  symbol index for the write.
- wr_data  in  2  nucleotide code to write.
- start  in  1  single-cycle run request.
- core_rst  out  1  reset driven to the core.
- valid  out  1  stream valid to the core.
- data_s  out  2  S symbol to the core.
- data_t  out  2  T symbol to the core.
- finish  in  1  completion flag from the core; sticky high once set.
- max  in  12  score from the core; valid while finish is high.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  timeout flag.
- result  out  12  captured score.

Behaviour:
- Reset values: all outputs are 0, state is IDLE, counters are 0, and both memories are cleared to 0.
- Reset mid-operation aborts the run immediately, with no done pulse.
- All outputs are registered.
- Writes:
  - Accepted only when busy=0: mem[wr_sel][wr_addr] <= wr_data.
  - Ignored while busy=1.
  - wr_addr >= INPUT_LENGTH is ignored.
- State machine states are IDLE, CLR, STREAM, WAIT, DONE.
- IDLE:
  - start=1 -> CLR.
  - On the same edge: error <= 0, result <= 0, counter <= 0.
  - start while busy is ignored.
  - A wr_en and start on the same edge in IDLE: the write is performed and the stream uses the new value.
- CLR:
  - core_rst=1 for exactly CLR_CYCLES cycles, then -> STREAM.
  - Timing: start sampled at edge N gives core_rst high in cycles N+1 .. N+CLR_CYCLES.
- STREAM:
  - valid=1 for exactly INPUT_LENGTH consecutive cycles, with no gaps.
  - In stream cycle k (k = 0..INPUT_LENGTH-1): data_s = S[k], data_t = T[k].
  - After cycle INPUT_LENGTH-1 -> WAIT.
  - Index wrap-around is not permitted; exit is decided on the last index.
- WAIT:
  - valid=0, data_s=0, data_t=0.
  - The wait counter increments every cycle.
  - finish=1 -> result <= max, done=1 for one cycle, -> DONE.
  - If the counter reaches TIMEOUT with finish=0 -> error <= 1, result <= 0, done=1, -> DONE.
  - If finish and timeout occur on the same cycle, finish wins (error stays 0).
- DONE:
  - Lasts one cycle, then -> IDLE.
  - result and error hold until the next start.
- finish high during CLR or STREAM is ignored. It is stale from a previous run and is cleared by core_rst.
- valid, data_s and data_t are 0 in every state other than STREAM.
- Wait counter is 16 bits wide and saturates.

Test Plan:
- Load S[i]=i%4, T[i]=(i+1)%4; start -> core_rst high 2 cycles, then valid high exactly 256 cycles with data_s at k=5 equal to 1 and data_t at k=5 equal to 2, valid low afterwards.
- Stub core raises finish with max=12'h5A3 on WAIT cycle 300 -> result=0x5A3, done pulse 1 cycle, error=0, busy low next cycle.
- Stub never asserts finish -> error=1, result=0, done after exactly 1024 WAIT cycles.
- finish asserted on the same cycle as timeout -> error=0, result captured.
- Write S[0]=3 while busy -> ignored, next run streams the old S[0]; a second start during STREAM has no effect on valid length.
- Assert reset during STREAM at k=100 -> valid=0, busy=0, and core_rst=0 immediately; memories read back 0 on the next run; no done pulse.
- Two back-to-back runs with identical stimulus -> identical result, and stale finish from run 1 is not captured during CLR or STREAM of run 2.
